// File: rtl/proyecto_pkg.sv
// Shared definitions for the colour-result UART transmitter: byte-level
// line states, the default frame header and the baud divider helper.
package proyecto_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 serialiser for one byte; a go arriving on the final stop-bit cycle
// chains straight into the next start bit so frame bytes stay back-to-back.
module uart_byte_tx
    import proyecto_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       go_i,
    input  logic [7:0] data_i,
    output logic       txd_o,
    output logic       byte_done_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

    uart_state_e   state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          bit_end;

    assign bit_end = (baud_q == LAST_TICK);

    // The line level is registered from the current state, so txd trails the state by one cycle.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        txd_d       = 1'b1;
        byte_done_o = 1'b0;
        case (state_q)
            UART_IDLE: begin
                if (go_i) begin
                    state_d = UART_START;
                    shift_d = data_i;
                    baud_d  = '0;
                end
            end
            UART_START: begin
                txd_d = 1'b0;
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = UART_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            UART_DATA: begin
                txd_d = shift_q[0];
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            UART_STOP: begin
                if (bit_end) begin
                    byte_done_o = 1'b1;
                    baud_d      = '0;
                    if (go_i) begin
                        state_d = UART_START;
                        shift_d = data_i;
                    end else begin
                        state_d = UART_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign txd_o = txd_q;

endmodule

// File: rtl/color_uart_tx.sv
// Sends HEADER, the latched colour byte and, when COLOR_UART_CHECKSUM_EN is
// defined, a HEADER^colour checksum byte as one back-to-back 8N1 frame.
module color_uart_tx
    import proyecto_pkg::*;
#(
    parameter int         CLK_HZ = 50_000_000,
    parameter int         BAUD   = 115_200,
    parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] color_code,
    output logic       uart_txd,
    output logic       busy,
    output logic       done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
`ifdef COLOR_UART_CHECKSUM_EN
    localparam logic [1:0] LAST_BYTE = 2'd2;
`else
    localparam logic [1:0] LAST_BYTE = 2'd1;
`endif

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] color_q, color_d;
    logic [1:0] next_idx;
    logic       accept;
    logic       byte_go;
    logic [7:0] byte_data;
    logic       byte_done;

    // A strobe landing on the done cycle is dropped, so acceptance also waits for done to clear.
    always_comb begin
        accept    = tx_start && !busy_q && !done_q;
        next_idx  = idx_q + 2'd1;
        byte_go   = 1'b0;
        byte_data = HEADER;
        busy_d    = busy_q;
        done_d    = 1'b0;
        idx_d     = idx_q;
        color_d   = color_q;
        if (accept) begin
            byte_go = 1'b1;
            busy_d  = 1'b1;
            idx_d   = 2'd0;
            color_d = color_code;
        end else if (busy_q && byte_done) begin
            if (idx_q == LAST_BYTE) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                idx_d  = 2'd0;
            end else begin
                byte_go   = 1'b1;
                idx_d     = next_idx;
                byte_data = color_q;
`ifdef COLOR_UART_CHECKSUM_EN
                if (next_idx == 2'd2) begin
                    byte_data = HEADER ^ color_q;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 2'd0;
            color_q <= 8'd0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            color_q <= color_d;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk_i      (clk),
        .rst_i      (rst),
        .go_i       (byte_go),
        .data_i     (byte_data),
        .txd_o      (uart_txd),
        .byte_done_o(byte_done)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_color_uart_tx.sv
// Testbench for color_uart_tx: every cycle compares txd/busy/done against a
// timeline model of the frame, plus line decoding and per-frame counts.
module tb_color_uart_tx;

    localparam int CPB = 10;
`ifdef COLOR_UART_CHECKSUM_EN
    localparam int NBYTES = 3;
`else
    localparam int NBYTES = 2;
`endif
    localparam int FRAME = NBYTES * 10 * CPB;
    localparam logic [7:0] HDR = 8'hAA;

    logic clk = 1'b0;
    logic rst;
    logic tx_start;
    logic [7:0] color_code;
    logic uart_txd;
    logic busy;
    logic done;

    int total = 0;
    int bad = 0;

    // Reference model: whether a frame is live, edges since its accept, and its payload.
    bit active = 1'b0;
    int n = 0;
    logic [7:0] mcode = 8'h00;

    int busyCycles = 0;
    int doneCount = 0;
    logic lineLog[$];

    always #5 clk = ~clk;

    color_uart_tx #(
        .CLK_HZ(1_000_000),
        .BAUD  (100_000),
        .HEADER(HDR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_start  (tx_start),
        .color_code(color_code),
        .uart_txd  (uart_txd),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [7:0] frameByte(input int b, input logic [7:0] code);
        if (b == 0) return HDR;
        if (b == 1) return code;
        return HDR ^ code;
    endfunction

    function automatic logic expTxd();
        int t;
        int pos;
        logic [7:0] byteVal;
        if (!active) return 1'b1;
        t = n - 1;
        if (t < 0 || t >= FRAME) return 1'b1;
        pos = (t % (10 * CPB)) / CPB;
        byteVal = frameByte(t / (10 * CPB), mcode);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return byteVal[pos - 1];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [7:0] code, input logic r);
        tx_start = start;
        color_code = code;
        rst = r;
        @(posedge clk);
        if (r) begin
            active = 1'b0;
        end else if (start && (!active || n > FRAME)) begin
            active = 1'b1;
            n = 0;
            mcode = code;
        end else if (active) begin
            n++;
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic checkOutput();
        check($sformatf("txd@%0t", $time), {31'd0, uart_txd}, {31'd0, expTxd()});
        check($sformatf("busy@%0t", $time), {31'd0, busy}, {31'd0, (active && n < FRAME)});
        check($sformatf("done@%0t", $time), {31'd0, done}, {31'd0, (active && n == FRAME)});
        lineLog.push_back(uart_txd);
        if (busy === 1'b1) busyCycles++;
        if (done === 1'b1) doneCount++;
    endtask

    // Strobe at cycle 0; optional extra strobe or reset at a given cycle; random codes elsewhere.
    task automatic runFrame(input logic [7:0] code, input int extraAt, input logic [7:0] extraCode,
                            input int resetAt, input int tail);
        applyStimulus(1'b1, code, 1'b0);
        for (int i = 1; i <= FRAME + tail; i++) begin
            if (i == resetAt) applyStimulus(1'b0, 8'($urandom), 1'b1);
            else if (i == extraAt) applyStimulus(1'b1, extraCode, 1'b0);
            else applyStimulus(1'b0, 8'($urandom), 1'b0);
        end
    endtask

    task automatic decodeCheck(input string tag, input int from, input logic [7:0] code);
        int s;
        int idx;
        logic [7:0] got;
        s = -1;
        for (int i = from; i < lineLog.size(); i++) begin
            if (lineLog[i] === 1'b0) begin
                s = i;
                break;
            end
        end
        check({tag, "_startfound"}, {31'd0, (s >= 0)}, 32'd1);
        if (s >= 0) begin
            for (int b = 0; b < NBYTES; b++) begin
                got = 8'hxx;
                for (int k = 0; k < 8; k++) begin
                    idx = s + b * 10 * CPB + (k + 1) * CPB + CPB / 2;
                    if (idx < lineLog.size()) got[k] = lineLog[idx];
                end
                check($sformatf("%s_byte%0d", tag, b), {24'd0, got}, {24'd0, frameByte(b, code)});
            end
        end
    endtask

    initial begin
        logic [7:0] rc;
        int gap;
        int extra;

        // Power-up reset, then a reset pulse while idle.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'($urandom), 1'b0);

        // Single frame with 0x3C.
        lineLog.delete();
        busyCycles = 0;
        doneCount = 0;
        runFrame(8'h3C, 0, 8'h00, 0, 10);
        check("single_busy_len", busyCycles, FRAME);
        check("single_done_cnt", doneCount, 1);
        decodeCheck("single", 0, 8'h3C);

        // Strobe while busy, then a strobe on the done cycle; both dropped.
        lineLog.delete();
        busyCycles = 0;
        doneCount = 0;
        runFrame(8'h01, 50, 8'h55, 0, 0);
        applyStimulus(1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'($urandom), 1'b0);
        check("ignore_busy_len", busyCycles, FRAME);
        check("ignore_done_cnt", doneCount, 1);
        decodeCheck("ignore", 0, 8'h01);

        // Reset at cycle 73 of a frame, then a clean frame.
        doneCount = 0;
        runFrame(8'hC3, 0, 8'h00, 73, -(FRAME - 73));
        check("rst_txd", {31'd0, uart_txd}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 2 * FRAME; i++) applyStimulus(1'b0, 8'($urandom), 1'b0);
        check("rst_no_done", doneCount, 0);
        lineLog.delete();
        runFrame(8'hF0, 0, 8'h00, 0, 5);
        decodeCheck("after_rst", 0, 8'hF0);

        // Back-to-back: strobe on the cycle after done.
        lineLog.delete();
        doneCount = 0;
        runFrame(8'h5A, 0, 8'h00, 0, 1);
        runFrame(8'hE7, 0, 8'h00, 0, 10);
        check("b2b_done_cnt", doneCount, 2);
        decodeCheck("b2b_first", 0, 8'h5A);
        decodeCheck("b2b_second", FRAME + 1, 8'hE7);

        // Random codes, gaps and stray strobes.
        for (int k = 0; k < 6; k++) begin
            rc = 8'($urandom);
            gap = $urandom_range(0, 3);
            extra = $urandom_range(1, FRAME + 2);
            lineLog.delete();
            runFrame(rc, extra, 8'($urandom), 0, 2 + gap);
            decodeCheck($sformatf("rand%0d", k), 0, rc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
